// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage constants: widths, the reset PC, the PC step and the bubble encoding.
// Decode uses the same opcode and NOP values, so they are kept here in one place.
package if_fetch_pkg;

    localparam int          DEF_W_PC     = 16;
    localparam int          DEF_W_INST   = 32;
    localparam int          W_OPC        = 7;

    // Opcode that decode treats as undefined. All of its control bits decode to 0.
    localparam logic [W_OPC-1:0] OPC_UNDEF = 7'b1111111;

    // The bubble is the undefined opcode in the top bits with every other bit zero.
    localparam logic [DEF_W_INST-1:0] DEF_NOP_INST = {OPC_UNDEF, {(DEF_W_INST-W_OPC){1'b0}}};

    localparam logic [DEF_W_PC-1:0] DEF_RESET_PC = 16'h0000;
    localparam logic [DEF_W_PC-1:0] DEF_PC_INC   = 16'h0001;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Owns the PC, drives a synchronous instruction memory
// with one cycle of read latency, and registers {inst, pc} for decode.
//
// Handshake: there is no valid/ready pair. Decode's stall_i means "hold": while
// it is high (and no redirect arrives) every register in this stage keeps its
// value, and inst_o/pc_value_o stay stable. A taken branch from execute
// overrides a stall and squashes the in-flight slot, so decode sees NOP bubbles
// until the first instruction from the branch target arrives.
//
// Pipeline slots:
//   pc_q              address being issued to the memory this cycle
//   infl_pc_q/infl_v_q address issued last cycle; its data is on imem_data_i now
//   inst_q/pcv_q      the registered outputs
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                W_PC     = DEF_W_PC,
    parameter int                W_INST   = DEF_W_INST,
    parameter logic [W_PC-1:0]   RESET_PC = DEF_RESET_PC,
    parameter logic [W_PC-1:0]   PC_INC   = DEF_PC_INC,
    parameter logic [W_INST-1:0] NOP_INST = DEF_NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              br_taken_i,
    input  logic [W_PC-1:0]   br_target_i,
    output logic              imem_en_o,
    output logic [W_PC-1:0]   imem_addr_o,
    input  logic [W_INST-1:0] imem_data_i,
    output logic [W_INST-1:0] inst_o,
    output logic [W_PC-1:0]   pc_value_o
);

    logic [W_PC-1:0]   pc_q;
    logic [W_PC-1:0]   infl_pc_q;
    logic              infl_v_q;
    logic [W_INST-1:0] inst_q;
    logic [W_PC-1:0]   pcv_q;

    // Memory is read every cycle out of reset. While stalled the in-flight
    // address is re-read so its data is still on imem_data_i when the stall
    // releases; this avoids a skid buffer at the cost of a stall_i->addr path.
    always_comb begin
        imem_en_o   = rst;
        imem_addr_o = stall_i ? infl_pc_q : pc_q;
    end

    // PC, in-flight slot and output registers: redirect beats stall beats advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            infl_pc_q <= '0;
            infl_v_q  <= 1'b0;
            inst_q    <= NOP_INST;
            pcv_q     <= '0;
        end else if (br_taken_i) begin
            // Squash the in-flight fetch so no pre-branch instruction escapes.
            pc_q      <= br_target_i;
            infl_v_q  <= 1'b0;
            inst_q    <= NOP_INST;
            pcv_q     <= '0;
        end else if (!stall_i) begin
            // PC wraps naturally modulo 2^W_PC.
            pc_q      <= pc_q + PC_INC;
            infl_pc_q <= pc_q;
            infl_v_q  <= 1'b1;
            inst_q    <= infl_v_q ? imem_data_i : NOP_INST;
            pcv_q     <= infl_v_q ? infl_pc_q : '0;
        end
    end

    assign inst_o     = inst_q;
    assign pc_value_o = pcv_q;

endmodule
